// File: rtl/sprite_line_fetch.sv
// sprite_line_fetch
//
// Walks the per-line object list from the highest entry down to entry 0.
// For each valid entry it reads the sprite's OAM attribute word, works out
// which 16-pixel row of the sprite falls on the current line, reads that
// row, and writes its non-transparent pixels into the line buffer. Because
// entries are visited in descending order, lower OAM indices are written
// last and so win overlapping pixels.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   obj_list       MAX_OBJ packed entries of OAM_ADDR_SIZE+1 bits each;
//                  entry i sits at [i*(OAM_ADDR_SIZE+1) +: OAM_ADDR_SIZE+1],
//                  bit 0 = valid, upper bits = OAM index
//   line_prepared  high while the object list for the current line is stable;
//                  its rising edge starts a fetch, dropping it aborts one
//   sy             current line number, latched when a fetch starts
//   oam_addr       OAM read address (registered)
//   oam_data       OAM word, valid one cycle after oam_addr:
//                  [30] y-flip [29] x-flip [28] priority [27:18] ypos
//                  [17:8] xpos [7:0] spriteref ([31] enable is not used)
//   spr_addr       sprite row address {spriteref, row} (registered)
//   spr_data       16 pixels x 4 bits, pixel p at [4p+3:4p], valid one cycle
//                  after spr_addr
//   lb_we          line buffer write strobe (registered)
//   lb_waddr       line buffer x address
//   lb_wdata       {priority, colour[3:0]}
//   line_done      every sprite of the current line has been drawn
//
// Timing: a valid entry costs 20 cycles (SCAN, OAM_WAIT, ATTR, ROW_WAIT and
// 16 DRAW cycles), an invalid entry costs one SCAN cycle. No line buffer clear
// is done here; the consumer clears on read.

module sprite_line_fetch #(
  parameter int MAX_OBJ       = 32,
  parameter int OAM_ADDR_SIZE = 6,
  parameter int LINE_WIDTH    = 640
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [MAX_OBJ*(OAM_ADDR_SIZE+1)-1:0] obj_list,
  input  logic                                 line_prepared,
  input  logic [9:0]                           sy,
  output logic [OAM_ADDR_SIZE-1:0]             oam_addr,
  input  logic [31:0]                          oam_data,
  output logic [11:0]                          spr_addr,
  input  logic [63:0]                          spr_data,
  output logic                                 lb_we,
  output logic [9:0]                           lb_waddr,
  output logic [4:0]                           lb_wdata,
  output logic                                 line_done
);

  localparam int               ENTRY_W  = OAM_ADDR_SIZE + 1;
  localparam int               IDX_W    = (MAX_OBJ > 1) ? $clog2(MAX_OBJ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_OBJ - 1);
  localparam logic [10:0]      X_LIMIT  = 11'(LINE_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    OAM_WAIT,
    ATTR,
    ROW_WAIT,
    DRAW,
    DONE
  } state_t;

  state_t state, next_state;

  logic             lp_prev;     // line_prepared one cycle ago, for edge detect
  logic [9:0]       sy_q;        // line number latched at fetch start
  logic [IDX_W-1:0] idx;         // object list entry being processed
  logic [3:0]       pix_cnt;     // pixel position within the sprite row
  logic             x_flip_q;
  logic             prio_q;
  logic [9:0]       xpos_q;
  logic [63:0]      spr_row_q;   // sprite row held for the rest of DRAW

  logic             start;
  logic             abort;
  logic [ENTRY_W-1:0] entry;
  logic             entry_valid;
  logic             last_entry;
  logic [9:0]       y_diff;
  logic [3:0]       row;
  logic [63:0]      row_bits;
  logic [3:0]       pix_sel;
  logic [3:0]       pixel;
  logic [10:0]      pix_x;
  logic             pix_write;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    start       = line_prepared & ~lp_prev;
    abort       = (state != IDLE) & ~line_prepared;
    entry       = obj_list[int'(idx)*ENTRY_W +: ENTRY_W];
    entry_valid = entry[0];
    last_entry  = (idx == '0);

    // Row within the sprite: low four bits of the 10-bit line difference,
    // mirrored for y-flip (~row == 15 - row for a 4-bit value).
    y_diff = sy_q - oam_data[27:18];
    row    = oam_data[30] ? ~y_diff[3:0] : y_diff[3:0];

    // On the first DRAW cycle the row is taken straight from spr_data and
    // captured at the same time; later cycles use the held copy, so the
    // sprite memory may change its output once DRAW has started.
    row_bits  = (pix_cnt == 4'd0) ? spr_data : spr_row_q;
    pix_sel   = x_flip_q ? ~pix_cnt : pix_cnt;
    pixel     = row_bits[{pix_sel, 2'b00} +: 4];
    pix_x     = {1'b0, xpos_q} + {7'd0, pix_cnt};
    // Colour 0 is transparent; pixels past the right edge are clipped.
    // Dropping line_prepared suppresses the write that would follow.
    pix_write = (state == DRAW) && line_prepared &&
                (pixel != 4'd0) && (pix_x < X_LIMIT);
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: asynchronous reset: the FSM and every output register return to
  // their idle values the moment reset is asserted, without waiting for clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (start) next_state = SCAN;
      SCAN: begin
        if (entry_valid)     next_state = OAM_WAIT;
        else if (last_entry) next_state = DONE;
      end
      OAM_WAIT: next_state = ATTR;
      ATTR:     next_state = ROW_WAIT;
      ROW_WAIT: next_state = DRAW;
      DRAW: begin
        if (pix_cnt == 4'd15) next_state = last_entry ? DONE : SCAN;
      end
      DONE:     next_state = DONE;
      default:  next_state = IDLE;
    endcase
    // Losing line_prepared anywhere outside IDLE abandons the line; in DONE
    // this is also the normal way back to IDLE.
    if (abort) next_state = IDLE;
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lp_prev   <= 1'b1;   // a line_prepared already high at release is not an edge
      sy_q      <= '0;
      idx       <= '0;
      pix_cnt   <= '0;
      x_flip_q  <= 1'b0;
      prio_q    <= 1'b0;
      xpos_q    <= '0;
      spr_row_q <= '0;
      oam_addr  <= '0;
      spr_addr  <= '0;
      lb_we     <= 1'b0;
      lb_waddr  <= '0;
      lb_wdata  <= '0;
      line_done <= 1'b0;
    end else begin
      lp_prev <= line_prepared;

      unique case (state)
        IDLE: begin
          if (start) begin
            sy_q <= sy;
            idx  <= LAST_IDX;
          end
        end
        SCAN: begin
          if (entry_valid) begin
            oam_addr <= entry[ENTRY_W-1:1];
          end else if (!last_entry) begin
            idx <= idx - 1'b1;
          end
        end
        ATTR: begin
          x_flip_q <= oam_data[29];
          prio_q   <= oam_data[28];
          xpos_q   <= oam_data[17:8];
          spr_addr <= {oam_data[7:0], row};
        end
        ROW_WAIT: begin
          pix_cnt <= 4'd0;
        end
        DRAW: begin
          pix_cnt <= pix_cnt + 4'd1;
          if (pix_cnt == 4'd0) spr_row_q <= spr_data;
          if (pix_cnt == 4'd15 && !last_entry) idx <= idx - 1'b1;
        end
        default: ;
      endcase

      // Each pixel is written one cycle after its DRAW cycle.
      lb_we <= pix_write;
      if (state == DRAW) begin
        lb_waddr <= pix_x[9:0];
        lb_wdata <= {prio_q, pixel};
      end

      line_done <= (next_state == DONE);
    end
  end

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Self-checking bench for sprite_line_fetch. OAM and sprite memories are
// modelled as synchronous ROMs; expected line buffer writes are queued when a
// line is set up and popped as the DUT issues lb_we.

module tb_sprite_line_fetch;

  localparam int MAX_OBJ = 32;
  localparam int OAM_AW  = 6;
  localparam int EW      = OAM_AW + 1;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [MAX_OBJ*EW-1:0]   obj_list;
  logic                    line_prepared;
  logic [9:0]              sy;
  logic [OAM_AW-1:0]       oam_addr;
  logic [31:0]             oam_data;
  logic [11:0]             spr_addr;
  logic [63:0]             spr_data;
  logic                    lb_we;
  logic [9:0]              lb_waddr;
  logic [4:0]              lb_wdata;
  logic                    line_done;

  logic [31:0] oam_mem [64];
  logic [63:0] spr_mem [4096];

  logic [14:0] exp_q [$];   // {waddr, wdata} in expected write order
  int          total = 0;
  int          bad   = 0;
  int          wr_count = 0;

  sprite_line_fetch #(
    .MAX_OBJ(MAX_OBJ), .OAM_ADDR_SIZE(OAM_AW), .LINE_WIDTH(640)
  ) dut (
    .clk(clk), .reset(reset), .obj_list(obj_list),
    .line_prepared(line_prepared), .sy(sy),
    .oam_addr(oam_addr), .oam_data(oam_data),
    .spr_addr(spr_addr), .spr_data(spr_data),
    .lb_we(lb_we), .lb_waddr(lb_waddr), .lb_wdata(lb_wdata),
    .line_done(line_done)
  );

  always #5 clk = ~clk;

  // Synchronous ROMs: data valid one cycle after the address.
  always @(posedge clk) begin
    oam_data <= oam_mem[oam_addr];
    spr_data <= spr_mem[spr_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Write monitor / scoreboard pop.
  always @(negedge clk) begin
    if (!reset && lb_we) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(lb_we), 64'd0);
      end else begin
        check("write", 64'({lb_waddr, lb_wdata}), 64'(exp_q.pop_front()));
      end
    end
  end

  function automatic logic [31:0] mk_oam(input logic yf, input logic xf, input logic pr,
                                         input logic [9:0] ypos, input logic [9:0] xpos,
                                         input logic [7:0] sref);
    return {1'b1, yf, xf, pr, ypos, xpos, sref};
  endfunction

  task automatic clear_cfg();
    obj_list = '0;
    for (int i = 0; i < 64; i++) oam_mem[i] = '0;
    for (int i = 0; i < 4096; i++) spr_mem[i] = '0;
    exp_q.delete();
  endtask

  task automatic set_entry(input int i, input int oam_idx);
    obj_list[i*EW +: EW] = {6'(oam_idx), 1'b1};
  endtask

  // Reference model: expected writes for the configured line, and the number
  // of cycles from the start edge to line_done.
  task automatic model_line(output int lat);
    logic [EW-1:0] e;
    logic [31:0]   a;
    logic [9:0]    d;
    logic [3:0]    r;
    logic [63:0]   rowv;
    logic [3:0]    px;
    logic [10:0]   x;
    lat = 1;
    for (int i = MAX_OBJ - 1; i >= 0; i--) begin
      e = obj_list[i*EW +: EW];
      if (!e[0]) begin
        lat += 1;
        continue;
      end
      lat += 20;
      a = oam_mem[e[EW-1:1]];
      d = sy - a[27:18];
      r = a[30] ? 4'(15 - d[3:0]) : d[3:0];
      rowv = spr_mem[{a[7:0], r}];
      for (int p = 0; p < 16; p++) begin
        px = a[29] ? rowv[4*(15-p) +: 4] : rowv[4*p +: 4];
        x  = 11'(a[17:8]) + 11'(p);
        if (px != 4'd0 && x < 11'd640) exp_q.push_back({x[9:0], a[28], px});
      end
    end
  endtask

  // Raise line_prepared, wait for line_done, check latency and scoreboard.
  task automatic run_line(input string tag, input int lat_exp);
    int cyc;
    wr_count = 0;
    @(negedge clk);
    line_prepared = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!line_done && cyc < 2000);
    check({tag, "_latency"}, 64'(cyc), 64'(lat_exp));
    @(negedge clk);
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    line_prepared = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_done_clear"}, 64'(line_done), 64'd0);
  endtask

  initial begin
    int lat;
    int cyc;

    // ---------------- reset, line_prepared high through release ----------
    clear_cfg();
    reset = 1'b1;
    line_prepared = 1'b1;
    sy = 10'd42;
    set_entry(0, 5);
    oam_mem[5] = mk_oam(0, 0, 0, 10'd40, 10'd100, 8'd3);
    spr_mem[12'h032] = 64'h21;
    #12;
    check("rst_oam_addr", 64'(oam_addr), 64'd0);
    check("rst_spr_addr", 64'(spr_addr), 64'd0);
    check("rst_lb_we", 64'(lb_we), 64'd0);
    check("rst_lb_waddr", 64'(lb_waddr), 64'd0);
    check("rst_lb_wdata", 64'(lb_wdata), 64'd0);
    check("rst_line_done", 64'(line_done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    wr_count = 0;
    repeat (60) @(negedge clk);
    check("no_start_done", 64'(line_done), 64'd0);
    check("no_start_writes", 64'(wr_count), 64'd0);
    line_prepared = 1'b0;
    @(negedge clk);

    // ---------------- single sprite, no flip ------------------------------
    exp_q.push_back({10'd100, 5'h01});
    exp_q.push_back({10'd101, 5'h02});
    run_line("basic", 20 + MAX_OBJ);
    check("basic_spr_addr", 64'(spr_addr), 64'h032);
    check("basic_writes", 64'(wr_count), 64'd2);

    // ---------------- x-flip ----------------------------------------------
    oam_mem[5] = mk_oam(0, 1, 0, 10'd40, 10'd100, 8'd3);
    exp_q.push_back({10'd114, 5'h02});
    exp_q.push_back({10'd115, 5'h01});
    run_line("xflip", 20 + MAX_OBJ);
    check("xflip_spr_addr", 64'(spr_addr), 64'h032);

    // ---------------- y-flip ----------------------------------------------
    oam_mem[5] = mk_oam(1, 0, 0, 10'd40, 10'd100, 8'd3);
    spr_mem[12'h032] = 64'h0000_0000_0000_0770;
    spr_mem[12'h03D] = 64'h21;
    exp_q.push_back({10'd100, 5'h01});
    exp_q.push_back({10'd101, 5'h02});
    run_line("yflip", 20 + MAX_OBJ);
    check("yflip_spr_addr", 64'(spr_addr), 64'h03D);

    // ---------------- right-edge clipping ---------------------------------
    clear_cfg();
    sy = 10'd42;
    set_entry(0, 5);
    oam_mem[5] = mk_oam(0, 0, 0, 10'd42, 10'd630, 8'd3);
    spr_mem[{8'd3, 4'd0}] = 64'hFFFF_FFFF_FFFF_FFFF;
    model_line(lat);
    run_line("clip", lat);
    check("clip_writes", 64'(wr_count), 64'd10);

    // ---------------- overlap, lower index wins ---------------------------
    clear_cfg();
    sy = 10'd42;
    set_entry(0, 1);
    set_entry(1, 2);
    oam_mem[1] = mk_oam(0, 0, 0, 10'd42, 10'd200, 8'd4);
    oam_mem[2] = mk_oam(0, 0, 1, 10'd42, 10'd200, 8'd5);
    spr_mem[{8'd4, 4'd0}] = 64'h1111_1111_1111_1111;
    spr_mem[{8'd5, 4'd0}] = 64'h2222_2222_2222_2222;
    for (int p = 0; p < 16; p++) exp_q.push_back({10'(200 + p), 5'h12});
    for (int p = 0; p < 16; p++) exp_q.push_back({10'(200 + p), 5'h01});
    run_line("overlap", 1 + (MAX_OBJ - 2) + 40);

    // ---------------- no valid entries ------------------------------------
    clear_cfg();
    run_line("empty", 1 + MAX_OBJ);
    check("empty_writes", 64'(wr_count), 64'd0);

    // ---------------- abort during DRAW p=7, then fresh fetch -------------
    clear_cfg();
    sy = 10'd42;
    set_entry(0, 7);
    oam_mem[7] = mk_oam(0, 0, 0, 10'd42, 10'd10, 8'd9);
    spr_mem[{8'd9, 4'd0}] = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int p = 0; p < 7; p++) exp_q.push_back({10'(10 + p), 5'h0F});
    wr_count = 0;
    @(negedge clk);
    line_prepared = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!lb_we && cyc < 200);
    check("abort_first_write_cycle", 64'(cyc), 64'd37);
    repeat (6) @(negedge clk);   // now in DRAW p=7
    line_prepared = 1'b0;
    @(negedge clk);
    check("abort_lb_we", 64'(lb_we), 64'd0);
    check("abort_line_done", 64'(line_done), 64'd0);
    repeat (20) @(negedge clk);
    check("abort_writes", 64'(wr_count), 64'd7);
    check("abort_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    model_line(lat);
    run_line("refetch", lat);
    check("refetch_writes", 64'(wr_count), 64'd16);

    // ---------------- randomised lines ------------------------------------
    for (int t = 0; t < 3; t++) begin
      clear_cfg();
      for (int i = 0; i < 4096; i++) spr_mem[i] = {$urandom, $urandom};
      for (int i = 0; i < 64; i++) oam_mem[i] = $urandom;
      for (int i = 0; i < MAX_OBJ; i++)
        if ($urandom_range(3) == 0) set_entry(i, int'($urandom_range(63)));
      sy = 10'($urandom_range(1023));
      model_line(lat);
      run_line($sformatf("rand%0d", t), lat);
    end

    // ---------------- reset asserted mid-fetch ----------------------------
    clear_cfg();
    sy = 10'd42;
    for (int i = 0; i < MAX_OBJ; i++) set_entry(i, 1);
    oam_mem[1] = mk_oam(0, 0, 1, 10'd42, 10'd50, 8'd3);
    spr_mem[{8'd3, 4'd0}] = 64'hFFFF_FFFF_FFFF_FFFF;
    model_line(lat);
    wr_count = 0;
    @(negedge clk);
    line_prepared = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (wr_count < 3 && cyc < 200);
    #2 reset = 1'b1;
    #1;
    check("midrst_lb_we", 64'(lb_we), 64'd0);
    check("midrst_line_done", 64'(line_done), 64'd0);
    check("midrst_oam_addr", 64'(oam_addr), 64'd0);
    check("midrst_spr_addr", 64'(spr_addr), 64'd0);
    check("midrst_lb_wdata", 64'(lb_wdata), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wr_count = 0;
    repeat (40) @(negedge clk);
    check("midrst_no_restart", 64'(wr_count), 64'd0);
    line_prepared = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
